// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type and BCD digit constants for the binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_W = 4;
  localparam int ADD3_TH = 5;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit of 5 or more
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_d,
  output logic [BCD_W-1:0] o_d
);
  always_comb o_d = (i_d >= BCD_W'(ADD3_TH)) ? i_d + BCD_W'(3) : i_d;
endmodule

// File: rtl/ula_bcd_conv.sv
// ula_bcd_conv: sequential double-dabble conversion of the ULA result to BCD digits for seg7
module ula_bcd_conv
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  input  logic             sinal_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       d0,
  output logic [3:0]       d1,
  output logic [3:0]       d2,
  output logic             sinal_out
);
  localparam int SW = BCD_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (DIGITS > 3) ? SW : 3 * BCD_W;
  localparam longint P10 = 64'd10 ** DIGITS;
  if (P10 <= (64'd1 << WIDTH) - 64'd1) begin : g_err
    $error("ula_bcd_conv: DIGITS too small for WIDTH");
  end
  state_t              r_st;
  logic [CW-1:0]       r_cnt;
  logic [SW-1:0]       r_scr;
  logic [WIDTH-1:0]    r_sh;
  logic                r_sgn, r_done, r_so;
  logic [3:0]          r_d0, r_d1, r_d2;
  logic [SW-1:0]       w_adj;
  logic [SW+WIDTH-1:0] w_nx;
  logic [PW-1:0]       w_pad;
  for (genvar i = 0; i < DIGITS; i++) begin : g_a
    bcd_add3 u_add3 (.i_d(r_scr[i*BCD_W +: BCD_W]), .o_d(w_adj[i*BCD_W +: BCD_W]));
  end
  assign w_nx  = {w_adj, r_sh} << 1;
  assign w_pad = PW'(r_scr);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_st   <= IDLE;
      r_cnt  <= '0;
      r_scr  <= '0;
      r_sh   <= '0;
      r_sgn  <= 1'b0;
      r_done <= 1'b0;
      r_so   <= 1'b0;
      r_d0   <= '0;
      r_d1   <= '0;
      r_d2   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_st)
        IDLE: if (start) begin
          r_sh  <= bin;
          r_scr <= '0;
          r_cnt <= CW'(WIDTH);
          r_sgn <= sinal_in;
          r_st  <= SHIFT;
        end
        SHIFT: begin
          {r_scr, r_sh} <= w_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_st <= DONE;
        end
        DONE: begin
          r_d0   <= w_pad[3:0];
          r_d1   <= w_pad[7:4];
          r_d2   <= w_pad[11:8];
          r_so   <= r_sgn;
          r_done <= 1'b1;
          r_st   <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
  assign busy      = r_st != IDLE;
  assign done      = r_done;
  assign d0        = r_d0;
  assign d1        = r_d1;
  assign d2        = r_d2;
  assign sinal_out = r_so;
endmodule

// File: tb/tb_ula_bcd_conv.sv
// tb_ula_bcd_conv: scoreboard bench, expected results queued at each accepted start and checked on done
module tb_ula_bcd_conv;
  logic       clk = 0, rst = 0, start = 0, sinal_in = 0;
  logic [7:0] bin = 0;
  logic       busy, done, sinal_out;
  logic [3:0] d0, d1, d2;
  int total = 0, bad = 0, cyc = 0;
  logic [12:0] q_v[$];
  int          q_c[$];
  ula_bcd_conv dut (.clk(clk), .rst(rst), .start(start), .bin(bin), .sinal_in(sinal_in),
                    .busy(busy), .done(done), .d0(d0), .d1(d1), .d2(d2), .sinal_out(sinal_out));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [12:0] ref_bcd(input int b, input logic s);
    logic [3:0] h, t, u;
    h = 4'(b / 100);
    t = 4'((b / 10) % 10);
    u = 4'(b % 10);
    return {s, h, t, u};
  endfunction
  always @(negedge clk) if (rst && done) begin
    if (q_v.size() == 0) chk("spurious_done", 1, 0);
    else begin
      chk("result", int'({sinal_out, d2, d1, d0}), int'(q_v.pop_front()));
      chk("latency", cyc, q_c.pop_front());
    end
  end
  task automatic go(input int b, input logic s, input bit exp);
    @(negedge clk);
    bin = 8'(b); sinal_in = s; start = 1;
    if (exp) begin q_v.push_back(ref_bcd(b, s)); q_c.push_back(cyc + 10); end
    @(negedge clk);
    start = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q_v.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin chk("timeout", 1, 0); q_v.delete(); q_c.delete(); end
    @(negedge clk);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_digits", int'({sinal_out, d2, d1, d0}), 0);
    rst = 1;
    go(255, 0, 1);
    n = 0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    chk("busy_cycles", n, 9);
    drain();
    repeat (4) @(negedge clk);
    chk("hold", int'({sinal_out, d2, d1, d0}), int'(ref_bcd(255, 0)));
    go(0, 0, 1); drain();
    go(100, 1, 1); drain();
    go(150, 0, 1);
    repeat (2) @(negedge clk);
    bin = 7; sinal_in = 1; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    drain();
    repeat (3) @(negedge clk);
    go(200, 1, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    chk("abort_digits", int'({sinal_out, d2, d1, d0}), 0);
    repeat (14) @(negedge clk);
    go(200, 0, 1); drain();
    @(negedge clk);
    bin = 37; sinal_in = 0; start = 1;
    q_v.push_back(ref_bcd(37, 0)); q_c.push_back(cyc + 10);
    @(negedge clk);
    bin = 99;
    q_v.push_back(ref_bcd(99, 0)); q_c.push_back(cyc + 19);
    repeat (10) @(negedge clk);
    start = 0;
    drain();
    for (int b = 0; b < 256; b++) begin
      go(b, b[0], 1);
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
